// File: rtl/lclk_pkg.sv
// -----------------------------------------------------------------------------
// lclk_pkg
//
// Shared definitions for the line-clock timer:
//   - CSR bit positions (monitor and interrupt-enable bits)
//   - default rate constants
//   - divisor and counter-width helper functions
// -----------------------------------------------------------------------------
package lclk_pkg;

  // CSR bit positions
  localparam int LCLK_MON_BIT = 7;
  localparam int LCLK_IE_BIT  = 6;

  // Default rates
  localparam int LCLK_DEF_CLK_HZ      = 50_000_000;
  localparam int LCLK_DEF_TICK_HZ     = 50;
  localparam int LCLK_DEF_TICK_HZ_ALT = 60;
  localparam int LCLK_DEF_DEB_STAGES  = 2;

  // Clock divisor for a given tick rate (floor division).
  function automatic int lclk_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Counter width able to hold 0 .. max(div_a, div_b)-1.
  function automatic int lclk_cnt_width(input int div_a, input int div_b);
    int m;
    m = (div_a > div_b) ? div_a : div_b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lclk_debounce.sv
// -----------------------------------------------------------------------------
// lclk_debounce
//
// Front-panel button conditioning for the line-clock timer. The raw button is
// brought into the clock domain with a 2-flop synchroniser, then sampled into
// a DEB_STAGES-deep shift register once per timer tick (tick_i is a clock
// enable, not a clock). When the register is all ones and the logic is armed,
// a one-cycle toggle pulse is produced and the logic disarms; it re-arms once
// the register has drained to all zeros.
//
// Ports:
//   clk_p     in   system clock
//   dclo_n    in   asynchronous active-low reset
//   tick_i    in   sample enable (one-cycle pulse at tick rate)
//   button_i  in   raw asynchronous button, active-high
//   toggle_o  out  one-cycle pulse requesting a run/stop toggle
// -----------------------------------------------------------------------------
module lclk_debounce
  import lclk_pkg::*;
#(
  parameter int DEB_STAGES = LCLK_DEF_DEB_STAGES
) (
  input  logic clk_p,
  input  logic dclo_n,
  input  logic tick_i,
  input  logic button_i,
  output logic toggle_o
);

  if (DEB_STAGES < 1) begin : g_bad_stages
    $error("lclk_debounce: DEB_STAGES must be >= 1");
  end

  logic [1:0]            sync_q, sync_d;
  logic [DEB_STAGES-1:0] sr_q, sr_d;
  logic [DEB_STAGES-1:0] sr_shift;
  logic                  armed_q, armed_d;
  logic                  all_ones, all_zeros;

  // Shift the synchronised sample in at the LSB end.
  if (DEB_STAGES == 1) begin : g_sr_one
    assign sr_shift = sync_q[1];
  end else begin : g_sr_many
    assign sr_shift = {sr_q[DEB_STAGES-2:0], sync_q[1]};
  end

  always_comb begin
    sync_d    = {sync_q[0], button_i};
    sr_d      = tick_i ? sr_shift : sr_q;
    all_ones  = &sr_q;
    all_zeros = ~|sr_q;
    toggle_o  = armed_q && all_ones;
    armed_d   = armed_q;
    if (toggle_o) begin
      armed_d = 1'b0;
    end else if (all_zeros) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_p or negedge dclo_n) begin
    if (!dclo_n) begin
      sync_q  <= '0;
      sr_q    <= '0;
      armed_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      sr_q    <= sr_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/line_clock_timer.sv
// -----------------------------------------------------------------------------
// line_clock_timer
//
// KW11-L class line-clock event generator. Divides clk_p down to one of two
// mains rates, gates the tick with a run/stop enable toggled by a debounced
// front-panel button, and holds a pending interrupt request (evnt_o) until
// the CPU acknowledges it. A sticky overrun flag records ticks that arrived
// while a request was still pending.
//
// Optional feature macro: LCLK_CSR_EN
//   defined   : Wishbone CSR with bit 7 = tick monitor, bit 6 = enable.
//   undefined : CSR inputs ignored, wb_ack_o / wb_dat_o held at 0, enable
//               controlled by the button alone.
//
// Ports:
//   clk_p       in   system clock, rising edge
//   dclo_n      in   asynchronous active-low reset
//   rate_sel_i  in   0 = TICK_HZ, 1 = TICK_HZ_ALT
//   button_i    in   raw on/off button, active-high
//   evnt_ack_i  in   one-cycle interrupt acknowledge
//   tick_o      out  one-cycle pulse at the selected rate, ungated
//   enable_o    out  timer run state (status LED)
//   evnt_o      out  pending interrupt request (level)
//   overrun_o   out  sticky overrun flag
//   wb_stb_i    in   CSR strobe (address-qualified)
//   wb_we_i     in   CSR write enable
//   wb_sel_i    in   CSR byte selects
//   wb_dat_i    in   CSR write data
//   wb_dat_o    out  CSR read data
//   wb_ack_o    out  CSR acknowledge
// -----------------------------------------------------------------------------
module line_clock_timer
  import lclk_pkg::*;
#(
  parameter int CLK_HZ      = LCLK_DEF_CLK_HZ,
  parameter int TICK_HZ     = LCLK_DEF_TICK_HZ,
  parameter int TICK_HZ_ALT = LCLK_DEF_TICK_HZ_ALT,
  parameter int DEB_STAGES  = LCLK_DEF_DEB_STAGES
) (
  input  logic        clk_p,
  input  logic        dclo_n,
  input  logic        rate_sel_i,
  input  logic        button_i,
  input  logic        evnt_ack_i,
  output logic        tick_o,
  output logic        enable_o,
  output logic        evnt_o,
  output logic        overrun_o,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o
);

  localparam int DIV     = lclk_div(CLK_HZ, TICK_HZ);
  localparam int DIV_ALT = lclk_div(CLK_HZ, TICK_HZ_ALT);
  localparam int CW      = lclk_cnt_width(DIV, DIV_ALT);

  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] LAST_ALT = CW'(DIV_ALT - 1);

  if ((DIV < 2) || (DIV_ALT < 2)) begin : g_bad_div
    $error("line_clock_timer: both clock divisors must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Rate divider
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_sel;
  logic          tick_q, tick_d;

  // Comparing with >= rather than == means a switch to a shorter period while
  // the counter is already past the new limit wraps on the next edge with a
  // single tick, instead of running on to the counter's full range.
  always_comb begin
    last_sel = rate_sel_i ? LAST_ALT : LAST;
    if (cnt_q >= last_sel) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Button debounce
  // ---------------------------------------------------------------------------
  logic toggle;

  lclk_debounce #(
    .DEB_STAGES (DEB_STAGES)
  ) u_debounce (
    .clk_p    (clk_p),
    .dclo_n   (dclo_n),
    .tick_i   (tick_q),
    .button_i (button_i),
    .toggle_o (toggle)
  );

  // ---------------------------------------------------------------------------
  // Interrupt request and overrun
  // ---------------------------------------------------------------------------
  logic en_q, en_d;
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;

  // A gated tick has priority over the acknowledge so a request arriving in
  // the ack cycle is never lost. Disabling the timer leaves a pending request
  // alone; only the CPU ack retires it.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (tick_q && en_q) begin
      pend_d = 1'b1;
      if (pend_q) begin
        ovr_d = 1'b1;
      end
    end else if (evnt_ack_i) begin
      pend_d = 1'b0;
    end
    if (evnt_ack_i && !tick_q) begin
      ovr_d = 1'b0;
    end
  end

`ifdef LCLK_CSR_EN
  // ---------------------------------------------------------------------------
  // Wishbone CSR
  // ---------------------------------------------------------------------------
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        mon_q, mon_d;
  logic        csr_wr;
  logic [15:0] csr_word;
  logic        unused_csr;

  // One ack per strobe: done_q blocks a second ack until the strobe drops.
  always_comb begin
    ack_d  = wb_stb_i && !ack_q && !done_q;
    done_d = wb_stb_i && (done_q || ack_q);
    csr_wr = ack_d && wb_we_i && wb_sel_i[0];

    mon_d = mon_q | tick_q;
    if (csr_wr && !wb_dat_i[LCLK_MON_BIT]) begin
      mon_d = 1'b0;
    end

    // A CSR write overrides a same-cycle button toggle.
    en_d = en_q ^ toggle;
    if (csr_wr) begin
      en_d = wb_dat_i[LCLK_IE_BIT];
    end

    csr_word               = '0;
    csr_word[LCLK_MON_BIT] = mon_q;
    csr_word[LCLK_IE_BIT]  = en_q;
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = ack_q ? csr_word : 16'h0000;
  assign unused_csr = ^{wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[5:0]};

  always_ff @(posedge clk_p or negedge dclo_n) begin
    if (!dclo_n) begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      mon_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      done_q <= done_d;
      mon_q  <= mon_d;
    end
  end
`else
  logic unused_csr;

  always_comb begin
    en_d = en_q ^ toggle;
  end

  assign wb_ack_o   = 1'b0;
  assign wb_dat_o   = 16'h0000;
  assign unused_csr = ^{wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i};
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_p or negedge dclo_n) begin
    if (!dclo_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign tick_o    = tick_q;
  assign enable_o  = en_q;
  assign evnt_o    = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_line_clock_timer.sv
// -----------------------------------------------------------------------------
// tb_line_clock_timer
//
// Directed bench for line_clock_timer with CLK_HZ=1000, TICK_HZ=50 (DIV=20),
// TICK_HZ_ALT=100 (DIV=10), DEB_STAGES=2. Cycle numbering: cycle 1 is the
// clock period between reset release and the first rising edge, so the
// observation at the k-th falling edge after release belongs to cycle k+1.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_line_clock_timer;

  logic        clk_p = 1'b0;
  logic        dclo_n;
  logic        rate_sel_i;
  logic        button_i;
  logic        evnt_ack_i;
  logic        tick_o;
  logic        enable_o;
  logic        evnt_o;
  logic        overrun_o;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_p = ~clk_p;

  line_clock_timer #(
    .CLK_HZ      (1000),
    .TICK_HZ     (50),
    .TICK_HZ_ALT (100),
    .DEB_STAGES  (2)
  ) dut (
    .clk_p      (clk_p),
    .dclo_n     (dclo_n),
    .rate_sel_i (rate_sel_i),
    .button_i   (button_i),
    .evnt_ack_i (evnt_ack_i),
    .tick_o     (tick_o),
    .enable_o   (enable_o),
    .evnt_o     (evnt_o),
    .overrun_o  (overrun_o),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("[%0t] %s obs=%0h exp=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count falling edges until tick_o is seen high; -1 if none within budget.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_p);
      if (tick_o === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tick"},    tick_o,    1'b0);
    chk({tag, "_enable"},  enable_o,  1'b0);
    chk({tag, "_evnt"},    evnt_o,    1'b0);
    chk({tag, "_overrun"}, overrun_o, 1'b0);
    chk({tag, "_wb_ack"},  wb_ack_o,  1'b0);
    chk({tag, "_wb_dat"},  wb_dat_o,  16'h0000);
  endtask

  initial begin
    int n;
    int en_at;
    int ev_at;
    int toggles;
    int lat;
    logic prev_en;

    dclo_n     = 1'b0;
    rate_sel_i = 1'b0;
    button_i   = 1'b0;
    evnt_ack_i = 1'b0;
    wb_stb_i   = 1'b0;
    wb_we_i    = 1'b0;
    wb_sel_i   = 2'b00;
    wb_dat_i   = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk_p);
    chk_all_zero("reset");

    // First tick in cycle DIV+1 = 21, then period DIV = 20
    dclo_n = 1'b1;
    wait_tick(n);
    chk("first_tick_cycle", n + 1, 21);
    chk("evnt_gated_off", evnt_o, 1'b0);
    wait_tick(n);
    chk("tick_period", n, 20);

    // Hold button 200 cycles: 2 sync + 2 ticks + 1 -> enable at +42,
    // next tick edge at +60, evnt visible at +61, overrun by +81.
    button_i = 1'b1;
    en_at    = -1;
    ev_at    = -1;
    toggles  = 0;
    prev_en  = enable_o;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_p);
      if (enable_o !== prev_en) begin
        toggles++;
        if (en_at < 0) en_at = i;
      end
      prev_en = enable_o;
      if (evnt_o === 1'b1 && ev_at < 0) ev_at = i;
    end
    chk("button_toggle_count", toggles, 1);
    chk("button_latency", en_at, 42);
    chk("evnt_rise_cycle", ev_at, 61);
    chk("enable_on", enable_o, 1'b1);
    chk("evnt_pending", evnt_o, 1'b1);
    chk("overrun_set", overrun_o, 1'b1);

    // Ack in a no-tick cycle clears request and overrun
    @(negedge clk_p);
    evnt_ack_i = 1'b1;
    @(negedge clk_p);
    evnt_ack_i = 1'b0;
    chk("ack_clears_evnt", evnt_o, 1'b0);
    chk("ack_clears_overrun", overrun_o, 1'b0);

    wait_tick(n);
    chk("tick_after_ack", n, 18);
    @(negedge clk_p);
    chk("evnt_reassert", evnt_o, 1'b1);

    // Ack coincident with a tick: request stays, overrun sets
    wait_tick(n);
    chk("tick_before_coinc", n, 19);
    evnt_ack_i = 1'b1;
    @(negedge clk_p);
    evnt_ack_i = 1'b0;
    chk("coinc_evnt_stays", evnt_o, 1'b1);
    chk("coinc_overrun", overrun_o, 1'b1);
    evnt_ack_i = 1'b1;
    @(negedge clk_p);
    evnt_ack_i = 1'b0;
    chk("ack2_clears_evnt", evnt_o, 1'b0);
    chk("ack2_clears_overrun", overrun_o, 1'b0);

    // Release for 3 ticks, press again -> enable returns to 0
    button_i = 1'b0;
    repeat (3) wait_tick(n);
    button_i = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_p);
      if (enable_o === 1'b0) begin
        lat = i;
        break;
      end
    end
    chk("button_off_latency", lat, 42);
    chk("disable_keeps_evnt", evnt_o, 1'b1);
    button_i   = 1'b0;
    evnt_ack_i = 1'b1;
    @(negedge clk_p);
    evnt_ack_i = 1'b0;
    chk("ack3_clears_evnt", evnt_o, 1'b0);
    wait_tick(n);
    @(negedge clk_p);
    chk("disabled_no_evnt", evnt_o, 1'b0);

    // Rate switch at counter = 15: wrap next edge, then period 10
    wait_tick(n);
    repeat (15) @(negedge clk_p);
    rate_sel_i = 1'b1;
    wait_tick(n);
    chk("rate_switch_wrap", n, 1);
    wait_tick(n);
    chk("alt_period", n, 10);
    rate_sel_i = 1'b0;
    wait_tick(n);
    chk("back_to_primary", n, 20);

`ifdef LCLK_CSR_EN
    // CSR write 0o000100 -> enable, single-cycle ack
    @(negedge clk_p);
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_sel_i = 2'b01;
    wb_dat_i = 16'o000100;
    @(negedge clk_p);
    chk("csr_wr_ack", wb_ack_o, 1'b1);
    chk("csr_wr_enable", enable_o, 1'b1);
    @(negedge clk_p);
    chk("csr_ack_single", wb_ack_o, 1'b0);
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;

    // After a tick, read -> 0o000300
    wait_tick(n);
    @(negedge clk_p);
    wb_stb_i = 1'b1;
    @(negedge clk_p);
    chk("csr_rd_ack", wb_ack_o, 1'b1);
    chk("csr_rd_300", wb_dat_o, 16'o000300);
    wb_stb_i = 1'b0;
    @(negedge clk_p);

    // Write 0o000100 clears monitor, keeps enable
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    @(negedge clk_p);
    chk("csr_wr2_ack", wb_ack_o, 1'b1);
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk_p);
    wb_stb_i = 1'b1;
    @(negedge clk_p);
    chk("csr_rd_100", wb_dat_o, 16'o000100);
    wb_stb_i = 1'b0;
`else
    // CSR disabled: strobes ignored
    @(negedge clk_p);
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_sel_i = 2'b01;
    wb_dat_i = 16'o000100;
    @(negedge clk_p);
    chk("nocsr_ack", wb_ack_o, 1'b0);
    chk("nocsr_dat", wb_dat_o, 16'h0000);
    chk("nocsr_enable", enable_o, 1'b0);
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;

    // Enable through the button instead
    wait_tick(n);
    button_i = 1'b1;
    repeat (45) @(negedge clk_p);
    chk("nocsr_button_enable", enable_o, 1'b1);
    button_i = 1'b0;
`endif

    // Reset mid-count with a request pending
    wait_tick(n);
    repeat (7) @(negedge clk_p);
    chk("pre_reset_evnt", evnt_o, 1'b1);
    dclo_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk_p);
    dclo_n = 1'b1;
    wait_tick(n);
    chk("post_reset_first_tick", n + 1, 21);
    chk("post_reset_enable", enable_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_clock_timer.md
# line_clock_timer

Parametrised line-clock (KW11-L class) event generator for the processor boards, feeding the CPU's `vm_evnt` input. It divides the system clock down to a selectable mains rate, gates the tick with a run/stop enable that a debounced front-panel button toggles, and holds a pending interrupt request until the CPU acknowledges it. An optional Wishbone-visible control/status register lets software read and drive the same enable.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 50: primary tick rate.
- `TICK_HZ_ALT`, default 60: alternate tick rate.
- `DEB_STAGES`, default 2: button samples, taken at tick rate, that must agree.
- `clk_p`  in  1  system clock; all state changes on its rising edge.
- `dclo_n`  in  1  reset, asynchronous, active-low.
- `rate_sel_i`  in  1  0 selects TICK_HZ; 1 selects TICK_HZ_ALT.
- `button_i`  in  1  raw timer on/off button, active-high, asynchronous.
- `evnt_ack_i`  in  1  one-cycle acknowledge from the CPU interrupt logic.
- `tick_o`  out  1  one-cycle pulse at the selected rate, ungated.
- `enable_o`  out  1  timer run state; also drives the status LED.
- `evnt_o`  out  1  pending interrupt request, a level signal.
- `overrun_o`  out  1  sticky flag: a tick arrived while a request was still pending.
- `wb_stb_i`, `wb_we_i`  in  1 each  CSR strobe, already address-qualified, and write enable.
- `wb_sel_i`  in  2  byte selects.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data.
- `wb_ack_o`  out  1  CSR acknowledge.

## Operation
- Divisor DIV = CLK_HZ / TICK_HZ, floor division. The same rule gives the alternate divisor from TICK_HZ_ALT. Both divisors must be ≥ 2; this is checked at elaboration.
- Counter width is clog2 of the larger divisor. The counter runs 0 … DIV−1 and then wraps to 0.
- The cycle after the counter equals DIV−1, `tick_o` is high for exactly one cycle.
- `rate_sel_i` is resampled every cycle. If the counter is at or above the new limit, it wraps on the next edge. No tick is lost or doubled.
- Button input:
  - `button_i` passes through a 2-flop synchroniser.
  - The synchronised value is shifted into a DEB_STAGES shift register, using `tick_o` as a clock enable. No derived clocks are used.
  - All ones while armed: toggle `enable_o`, then disarm.
  - All zeros: re-arm.
- Interrupt request:
  - A tick while `enable_o` = 1 sets the pending flag; `evnt_o` reflects that flag.
  - `evnt_ack_i` clears it.
  - Tick and ack in the same cycle: the flag stays set.
- Overrun: a tick with `enable_o` = 1 while the request is already pending sets `overrun_o`. An ack without a simultaneous tick clears it.
- Clearing `enable_o` does not clear a pending request.
- Reset in mid-operation clears everything immediately, including any partial debounce history.

## Timing
- Reset values:
  - `tick_o`, `enable_o`, `evnt_o`, `overrun_o`, `wb_ack_o`: 0.
  - `wb_dat_o`: 0.
  - Counter, shift register: 0.
  - Debounce logic: armed.
- First `tick_o` comes DIV+1 cycles after `dclo_n` deasserts. After that, the tick period is DIV cycles.
- `evnt_o` rises on the edge after `tick_o`. It falls on the edge after `evnt_ack_i`.
- Button latency: 2 sync cycles, then DEB_STAGES ticks to fill the register, then one more cycle for `enable_o` to change.
- CSR handshake:
  - `wb_ack_o` rises on the edge after `wb_stb_i` is sampled high, stays high for one cycle, then returns low. It re-arms only after `wb_stb_i` has been low.
  - A write commits on the same edge that raises `wb_ack_o`.
  - Read data is valid while `wb_ack_o` is high.

## Configuration
- `LCLK_CSR_EN` defined:
  - CSR bit 7 (monitor) is set on every `tick_o`. A write with `wb_sel_i[0]` = 1 and bit 7 = 0 clears it; writing 1 to bit 7 has no effect.
  - CSR bit 6 reads `enable_o`. A write with `wb_sel_i[0]` = 1 loads bit 6 into `enable_o`.
  - A write and a button toggle in the same cycle: the write wins.
  - All other bits read 0 and ignore writes.
- `LCLK_CSR_EN` undefined:
  - The CSR ports remain, with the inputs ignored.
  - `wb_ack_o` and `wb_dat_o` are held at 0.
  - `enable_o` is controlled by the button only.

## Structure
- Shared package `lclk_pkg`:
  - CSR bit positions: `LCLK_MON_BIT` = 7, `LCLK_IE_BIT` = 6.
  - Divisor and width functions.
  - Default rate constants.
- Sub-module `lclk_debounce`: synchroniser, tick-enabled shift register, and arm/disarm logic. It outputs a one-cycle `toggle` pulse.

## Test plan
- CLK_HZ = 1000, TICK_HZ = 50, release reset → `tick_o` pulses at cycle 21, then every 20 cycles; `evnt_o` stays 0 because `enable_o` = 0.
- Hold `button_i` = 1 for 200 cycles with DEB_STAGES = 2 → `enable_o` toggles exactly once and `evnt_o` rises after the next tick. Release for 3 ticks and press again → `enable_o` returns to 0.
- With `enable_o` = 1, never ack for 2 ticks → `evnt_o` = 1 and `overrun_o` = 1. Ack in a no-tick cycle → both clear. Ack coincident with a tick → `evnt_o` stays 1.
- Switch `rate_sel_i` to 1 (TICK_HZ_ALT = 100, DIV = 10) at counter = 15 → wrap on the next edge, then tick period 10.
- With `LCLK_CSR_EN` defined:
  - Write 16'o000100 → `enable_o` = 1 and `wb_ack_o` pulses for 1 cycle.
  - After a tick, read → 16'o000300.
  - Write 16'o000100 → bit 7 clears.
- Assert `dclo_n` low mid-count with `evnt_o` = 1 → all outputs are 0 immediately, and the first tick comes DIV+1 cycles after release.
